id_pipe: RTL and testbench
==========================

# id_pipe

Parametrised instruction-decode stage for the pipelined processor: decodes a 32-bit instruction, reads a multi-register file with write-back bypass, sign-extends the immediate, and holds all results in an ID/EX pipeline register with valid/ready handshakes, stall, flush and load-use bubble insertion. It sits between the fetch stage (IF) and the execute stage (EX), and receives the write-back port from WB.

## Interface
- XLEN, 32: datapath width of register file, PRA, PRB and outSE.
- NREG, 32: register count; power of two, 2..32; AW = clog2(NREG).
- IMM_W, 15: immediate field width, taken from instruction[IMM_W-1:0]; 8..15.
- ZERO_R0, 1: when 1, register 0 always reads 0 and ignores writes.

- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-low reset.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  ID accepts the instruction this cycle.
- instruction  in  32  instruction word.
- WPC  in  32  PC of the instruction.
- flush  in  1  EX redirect; kills the instruction being accepted and the ID/EX content.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX consumes the ID/EX register this cycle.
- WB_EN, WB_ADDR[AW], WB_DATA[XLEN]  in  write-back port.
- PRA, PRB, outSE  out  XLEN  operand A, operand B, sign-extended immediate.
- OP_ALU  out  5;  cond  out  3;  rd  out  AW;  PC_o  out  32.
- W_DM, W_RF, S_MXPC, S_MXSE  out  1;  S_MXRB  out  2;  MEM_RD  out  1 (load marker).

## Operation
- Fields: fmt=[31:30], func=[29:25], rd=[24:20], ra=[19:15], rb=[14:10]. Register indices use the low AW bits.
- fmt 00 ALU reg-reg: OP_ALU=func, W_RF=1, S_MXRB=00, S_MXSE=0.
- fmt 01 ALU immediate: as fmt 00, but S_MXSE=1.
- fmt 10 memory: OP_ALU=ADD (00000), S_MXSE=1. func[0]=1 is a store: W_DM=1, PRB=reg[rd]. func[0]=0 is a load: W_RF=1, MEM_RD=1, S_MXRB=01.
- fmt 11 branch: cond=func[2:0], S_MXPC=1, S_MXSE=1. func[4]=1 is jump-and-link: W_RF=1, S_MXRB=10.
- All other outputs are 0 for each format.
- outSE = instruction[IMM_W-1:0] sign-extended to XLEN.
- Register file: two combinational read ports and one synchronous write port. Bypass: a read of WB_ADDR while WB_EN=1 returns WB_DATA in the same cycle. With ZERO_R0=1, reg 0 reads 0 and bypass is suppressed for it. All registers clear on reset.
- Load-use hazard: ID/EX holds a valid load (MEM_RD=1) and the incoming instruction reads its rd. Reads means ra, or rb for fmt 00, or rd for stores. A fmt 01 instruction does not read rb. In this case in_ready=0 and one bubble (out_valid=0) is inserted once EX consumes the load. Register 0 never hazards when ZERO_R0=1.
- Handshake: in_ready = (~out_valid | out_ready) & ~hazard. The transfer fires on in_valid & in_ready. When out_valid=1 and out_ready=0, all ID/EX outputs hold stable.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears on the outputs after edge N; the register file is read in the acceptance cycle.
- Reset (RST=0 at an edge): out_valid=0 and every ID/EX output is 0, including PRA, PRB, outSE, OP_ALU, cond, rd and all strobes. The register file clears. in_ready is 0 while RST=0.
- Flush: out_valid=0 at the next edge, whatever in_valid and out_ready are doing. A same-cycle write-back still commits.
- Flush has priority over hazard, and hazard has priority over acceptance.
- When out_valid=0, the control strobes W_DM and W_RF are forced to 0 at the outputs.
- Write-back to a register in the same cycle as its read: the bypassed value is captured.

## Structure
- Shared package id_pkg:
  - fmt codes FMT_ALU, FMT_ALUI, FMT_MEM, FMT_BR.
  - S_MXRB encodings MXRB_ALU=00, MXRB_MEM=01, MXRB_LINK=10.
  - ALU_ADD=5'b00000.
  - Field bit positions.
- Sub-module regfile_bp: parametrised by XLEN, NREG and ZERO_R0. It contains the register array, the synchronous write, and the two bypassed read ports.
- The decode, hazard and pipeline-register logic live in id_pipe.

## Test plan
- Reset, then fmt 00 func=00011 rd=3 ra=1 rb=2, with reg1=5 and reg2=7 written through WB. One cycle later: out_valid=1, OP_ALU=00011, PRA=5, PRB=7, W_RF=1, S_MXRB=00.
- fmt 01 with imm=15'h7FFE and XLEN=32 -> outSE=32'hFFFFFFFE, S_MXSE=1. Repeat with imm=15'h0005 -> outSE=5.
- Load rd=4, followed by an add with ra=4 -> in_ready=0 for one cycle, one bubble (out_valid=0), then the add issues. Repeat with ra=0 and ZERO_R0=1 -> no bubble.
- WB_EN=1, WB_ADDR=6, WB_DATA=32'hA5A5A5A5 in the same cycle an instruction reads ra=6 -> PRA=32'hA5A5A5A5.
- out_ready held 0 for 3 cycles with in_valid=1 -> outputs stable and in_ready=0. Flush asserted on cycle 2 -> out_valid=0 at the next edge.
- Branch fmt 11 func=10101 -> cond=101, S_MXPC=1, W_RF=1, S_MXRB=10. Assert RST mid-stream -> all outputs 0 at the next edge and reg reads return 0.

Source files
------------

// File: rtl/id_pkg.sv
// id_pkg: shared definitions for the instruction-decode stage.
//   - instruction format codes and field positions
//   - write-back mux encodings, ALU add opcode
//   - ctrl_t: control bundle carried in the ID/EX register
//   - decode_ctrl(): maps an instruction word to its control bundle
package id_pkg;

   typedef enum logic [1:0] {
      FMT_ALU  = 2'b00,
      FMT_ALUI = 2'b01,
      FMT_MEM  = 2'b10,
      FMT_BR   = 2'b11
   } fmt_e;

   typedef enum logic [1:0] {
      MXRB_ALU  = 2'b00,
      MXRB_MEM  = 2'b01,
      MXRB_LINK = 2'b10
   } mxrb_e;

   localparam logic [4:0] ALU_ADD = 5'b00000;

   localparam int unsigned FMT_LSB  = 30;
   localparam int unsigned FUNC_LSB = 25;
   localparam int unsigned RD_LSB   = 20;
   localparam int unsigned RA_LSB   = 15;
   localparam int unsigned RB_LSB   = 10;

   typedef struct packed {
      logic [4:0] op_alu;
      logic [2:0] cond;
      logic       w_dm;
      logic       w_rf;
      logic       s_mxpc;
      logic       s_mxse;
      mxrb_e      s_mxrb;
      logic       mem_rd;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input logic [31:0] ins);
      ctrl_t      c;
      fmt_e       fmt;
      logic [4:0] func;
      c    = '0;
      fmt  = fmt_e'(ins[FMT_LSB +: 2]);
      func = ins[FUNC_LSB +: 5];
      case (fmt)
         FMT_ALU: begin
            c.op_alu = func;
            c.w_rf   = 1'b1;
         end
         FMT_ALUI: begin
            c.op_alu = func;
            c.w_rf   = 1'b1;
            c.s_mxse = 1'b1;
         end
         FMT_MEM: begin
            c.op_alu = ALU_ADD;
            c.s_mxse = 1'b1;
            if (func[0]) begin
               c.w_dm = 1'b1;
            end else begin
               c.w_rf   = 1'b1;
               c.mem_rd = 1'b1;
               c.s_mxrb = MXRB_MEM;
            end
         end
         FMT_BR: begin
            c.cond   = func[2:0];
            c.s_mxpc = 1'b1;
            c.s_mxse = 1'b1;
            if (func[4]) begin
               c.w_rf   = 1'b1;
               c.s_mxrb = MXRB_LINK;
            end
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_pipe_regfile_bp.sv
// regfile_bp: register file with two combinational read ports, one
// synchronous write port and write-back bypass.
// Ports:
//   clk            clock
//   rst            synchronous active-low reset, clears every register
//   we/waddr/wdata write port (also the bypass source)
//   raddr_a/b      read addresses
//   rdata_a/b      read data (bypassed)
module regfile_bp #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NREG    = 32,
   parameter bit          ZERO_R0 = 1'b1,
   localparam int unsigned AW     = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr_a,
   input  logic [AW-1:0]   raddr_b,
   output logic [XLEN-1:0] rdata_a,
   output logic [XLEN-1:0] rdata_b
);

   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && !(ZERO_R0 && waddr == '0)) begin
         regs[waddr] <= wdata;
      end
   end

   // Register 0 wins over the bypass so a write-back to r0 is invisible.
   assign rdata_a = (ZERO_R0 && raddr_a == '0)  ? '0    :
                    (we && waddr == raddr_a)    ? wdata : regs[raddr_a];
   assign rdata_b = (ZERO_R0 && raddr_b == '0)  ? '0    :
                    (we && waddr == raddr_b)    ? wdata : regs[raddr_b];

endmodule

// File: rtl/id_pipe.sv
// id_pipe: instruction-decode stage with ID/EX pipeline register.
// Ports:
//   CLK, RST                 clock, synchronous active-low reset
//   in_valid/in_ready        IF -> ID handshake; instruction, WPC
//   flush                    kills the accepting instruction and ID/EX content
//   out_valid/out_ready      ID -> EX handshake
//   WB_EN/WB_ADDR/WB_DATA    register-file write-back port
//   PRA, PRB, outSE          operands and sign-extended immediate
//   OP_ALU, cond, rd, PC_o   decoded fields
//   W_DM, W_RF, S_MXPC, S_MXSE, S_MXRB, MEM_RD  control strobes
module id_pipe
   import id_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NREG    = 32,
   parameter int unsigned IMM_W   = 15,
   parameter bit          ZERO_R0 = 1'b1,
   localparam int unsigned AW     = $clog2(NREG)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruction,
   input  logic [31:0]     WPC,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   input  logic            WB_EN,
   input  logic [AW-1:0]   WB_ADDR,
   input  logic [XLEN-1:0] WB_DATA,
   output logic [XLEN-1:0] PRA,
   output logic [XLEN-1:0] PRB,
   output logic [XLEN-1:0] outSE,
   output logic [4:0]      OP_ALU,
   output logic [2:0]      cond,
   output logic [AW-1:0]   rd,
   output logic [31:0]     PC_o,
   output logic            W_DM,
   output logic            W_RF,
   output logic            S_MXPC,
   output logic            S_MXSE,
   output logic [1:0]      S_MXRB,
   output logic            MEM_RD
);

   fmt_e            f_fmt;
   logic [AW-1:0]   f_rd, f_ra, f_rb, rb_sel;
   logic            store, reads_q, hazard, fire;
   ctrl_t           dec;
   logic [XLEN-1:0] rd_a, rd_b, se;

   logic            q_valid;
   ctrl_t           q_ctrl;
   logic [AW-1:0]   q_rd;
   logic [31:0]     q_pc;
   logic [XLEN-1:0] q_pra, q_prb, q_se;

   assign f_fmt  = fmt_e'(instruction[FMT_LSB +: 2]);
   assign f_rd   = instruction[RD_LSB +: AW];
   assign f_ra   = instruction[RA_LSB +: AW];
   assign f_rb   = instruction[RB_LSB +: AW];
   assign store  = (f_fmt == FMT_MEM) && instruction[FUNC_LSB];
   // Stores source their data operand from the rd field.
   assign rb_sel = store ? f_rd : f_rb;
   assign dec    = decode_ctrl(instruction);
   assign se     = {{(XLEN-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};

   regfile_bp #(.XLEN(XLEN), .NREG(NREG), .ZERO_R0(ZERO_R0)) u_rf (
      .clk     (CLK),
      .rst     (RST),
      .we      (WB_EN),
      .waddr   (WB_ADDR),
      .wdata   (WB_DATA),
      .raddr_a (f_ra),
      .raddr_b (rb_sel),
      .rdata_a (rd_a),
      .rdata_b (rd_b)
   );

   // Load-use: the incoming instruction needs the result of the load in ID/EX.
   assign reads_q = (f_ra == q_rd)
                  | ((f_fmt == FMT_ALU) && (f_rb == q_rd))
                  | (store && (f_rd == q_rd));
   assign hazard  = in_valid & q_valid & q_ctrl.mem_rd & reads_q
                  & !(ZERO_R0 && q_rd == '0);
   assign in_ready = RST & (~q_valid | out_ready) & ~hazard;
   assign fire     = in_valid & in_ready;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         q_valid <= 1'b0;
         q_ctrl  <= '0;
         q_rd    <= '0;
         q_pc    <= '0;
         q_pra   <= '0;
         q_prb   <= '0;
         q_se    <= '0;
      end else if (flush) begin
         q_valid <= 1'b0;
      end else if (fire) begin
         q_valid <= 1'b1;
         q_ctrl  <= dec;
         q_rd    <= f_rd;
         q_pc    <= WPC;
         q_pra   <= rd_a;
         q_prb   <= rd_b;
         q_se    <= se;
      end else if (out_ready) begin
         q_valid <= 1'b0;
      end
   end

   assign out_valid = q_valid;
   assign PRA       = q_pra;
   assign PRB       = q_prb;
   assign outSE     = q_se;
   assign OP_ALU    = q_ctrl.op_alu;
   assign cond      = q_ctrl.cond;
   assign rd        = q_rd;
   assign PC_o      = q_pc;
   assign W_DM      = q_valid & q_ctrl.w_dm;
   assign W_RF      = q_valid & q_ctrl.w_rf;
   assign S_MXPC    = q_ctrl.s_mxpc;
   assign S_MXSE    = q_ctrl.s_mxse;
   assign S_MXRB    = q_ctrl.s_mxrb;
   assign MEM_RD    = q_ctrl.mem_rd;

endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: self-checking bench for id_pipe with a behavioural model of
// the decode stage, directed literal checks and a randomized phase.
module tb_id_pipe;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREG  = 32;
   localparam int unsigned IMM_W = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, flush, out_ready, wb_en;
   logic [31:0] instr, wpc, wb_data;
   logic [4:0]  wb_addr;

   logic        in_ready, out_valid, W_DM, W_RF, S_MXPC, S_MXSE, MEM_RD;
   logic [31:0] PRA, PRB, outSE, PC_o;
   logic [4:0]  OP_ALU, rd;
   logic [2:0]  cond;
   logic [1:0]  S_MXRB;

   id_pipe #(.XLEN(XLEN), .NREG(NREG), .IMM_W(IMM_W), .ZERO_R0(1'b1)) dut (
      .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instr), .WPC(wpc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .WB_EN(wb_en), .WB_ADDR(wb_addr), .WB_DATA(wb_data),
      .PRA(PRA), .PRB(PRB), .outSE(outSE), .OP_ALU(OP_ALU), .cond(cond),
      .rd(rd), .PC_o(PC_o), .W_DM(W_DM), .W_RF(W_RF), .S_MXPC(S_MXPC),
      .S_MXSE(S_MXSE), .S_MXRB(S_MXRB), .MEM_RD(MEM_RD)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // ---------------- behavioural model ----------------
   logic [31:0] mr [32];
   bit          m_valid, m_zeroed;
   logic [4:0]  m_op, m_rd;
   logic [2:0]  m_cond;
   logic [31:0] m_pc, m_pra, m_prb, m_se;
   bit          m_wdm, m_wrf, m_mxpc, m_mxse, m_memrd;
   logic [1:0]  m_mxrb;

   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (wb_en && wb_addr == a) return wb_data;
      return mr[a];
   endfunction

   function automatic bit m_hazard();
      logic [1:0] f;
      logic [4:0] fn, d, a, b;
      f = instr[31:30]; fn = instr[29:25]; d = instr[24:20];
      a = instr[19:15]; b = instr[14:10];
      if (!in_valid || !m_valid || !m_memrd || m_rd == 0) return 1'b0;
      return (a == m_rd) || (f == 2'd0 && b == m_rd) || (f == 2'd2 && fn[0] && d == m_rd);
   endfunction

   function automatic bit m_ready();
      return rst && (!m_valid || out_ready) && !m_hazard();
   endfunction

   always @(posedge clk) begin : model
      bit         rdy;
      logic [1:0] f;
      logic [4:0] fn, d;
      int         v;
      rdy = m_ready();
      if (!rst) begin
         for (int i = 0; i < 32; i++) mr[i] = '0;
         m_valid = 0; m_zeroed = 1;
         m_op = 0; m_rd = 0; m_cond = 0; m_pc = 0; m_pra = 0; m_prb = 0; m_se = 0;
         m_wdm = 0; m_wrf = 0; m_mxpc = 0; m_mxse = 0; m_memrd = 0; m_mxrb = 0;
      end else begin
         if (flush) begin
            m_valid = 0;
         end else if (in_valid && rdy) begin
            f = instr[31:30]; fn = instr[29:25]; d = instr[24:20];
            m_valid = 1; m_zeroed = 0;
            m_rd  = d;
            m_pc  = wpc;
            m_pra = mread(instr[19:15]);
            m_prb = (f == 2'd2 && fn[0]) ? mread(d) : mread(instr[14:10]);
            v = int'(instr[14:0]);
            if (v >= 16384) v = v - 32768;
            m_se = 32'(v);
            m_op = 0; m_cond = 0; m_wdm = 0; m_wrf = 0; m_mxpc = 0;
            m_mxse = 0; m_memrd = 0; m_mxrb = 0;
            if (f == 2'd0 || f == 2'd1) begin
               m_op = fn; m_wrf = 1; m_mxse = (f == 2'd1);
            end else if (f == 2'd2) begin
               m_mxse = 1;
               if (fn[0]) m_wdm = 1;
               else begin m_wrf = 1; m_memrd = 1; m_mxrb = 2'd1; end
            end else begin
               m_cond = fn[2:0]; m_mxpc = 1; m_mxse = 1;
               if (fn[4]) begin m_wrf = 1; m_mxrb = 2'd2; end
            end
         end else if (out_ready) begin
            m_valid = 0;
         end
         if (wb_en && wb_addr != 0) mr[wb_addr] = wb_data;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic compare();
      chk("in_ready", 64'(in_ready), 64'(m_ready()));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("W_DM", 64'(W_DM), 64'(m_valid & m_wdm));
      chk("W_RF", 64'(W_RF), 64'(m_valid & m_wrf));
      if (m_valid || m_zeroed) begin
         chk("PRA", 64'(PRA), 64'(m_pra));
         chk("PRB", 64'(PRB), 64'(m_prb));
         chk("outSE", 64'(outSE), 64'(m_se));
         chk("OP_ALU", 64'(OP_ALU), 64'(m_op));
         chk("cond", 64'(cond), 64'(m_cond));
         chk("rd", 64'(rd), 64'(m_rd));
         chk("PC_o", 64'(PC_o), 64'(m_pc));
         chk("S_MXPC", 64'(S_MXPC), 64'(m_mxpc));
         chk("S_MXSE", 64'(S_MXSE), 64'(m_mxse));
         chk("S_MXRB", 64'(S_MXRB), 64'(m_mxrb));
         chk("MEM_RD", 64'(MEM_RD), 64'(m_memrd));
      end
   endtask

   function automatic logic [31:0] mk(input int unsigned fmt, input int unsigned func,
                                      input int unsigned d, input int unsigned a,
                                      input logic [14:0] low);
      logic [31:0] w;
      w = '0;
      w[31:30] = fmt[1:0];
      w[29:25] = func[4:0];
      w[24:20] = d[4:0];
      w[19:15] = a[4:0];
      w[14:0]  = low;
      return w;
   endfunction

   function automatic logic [31:0] mk_r(input int unsigned fmt, input int unsigned func,
                                        input int unsigned d, input int unsigned a,
                                        input int unsigned b);
      return mk(fmt, func, d, a, {b[4:0], 10'd0});
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 0; in_valid = 0; flush = 0; out_ready = 1; wb_en = 0;
      wb_addr = 0; wb_data = 0; instr = 0; wpc = 0;
      tick(); tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_PRA", 64'(PRA), 64'd0);
      chk("rst_outSE", 64'(outSE), 64'd0);
      chk("rst_OP_ALU", 64'(OP_ALU), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);

      fork
         forever begin
            @(negedge clk);
            compare();
         end
      join_none

      // register writes through WB, then an ALU reg-reg instruction
      rst = 1; wb_en = 1; wb_addr = 1; wb_data = 5;
      tick();
      wb_addr = 2; wb_data = 7;
      tick();
      wb_en = 0;
      instr = mk_r(0, 3, 3, 1, 2); wpc = 32'h100; in_valid = 1;
      #1 chk("alu_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("alu_valid", 64'(out_valid), 64'd1);
      chk("alu_op", 64'(OP_ALU), 64'd3);
      chk("alu_PRA", 64'(PRA), 64'd5);
      chk("alu_PRB", 64'(PRB), 64'd7);
      chk("alu_W_RF", 64'(W_RF), 64'd1);
      chk("alu_S_MXRB", 64'(S_MXRB), 64'd0);
      chk("alu_PC", 64'(PC_o), 64'h100);

      // immediate sign extension
      instr = mk(1, 0, 5, 1, 15'h7FFE);
      tick();
      chk("imm_neg", 64'(outSE), 64'hFFFF_FFFE);
      chk("imm_mxse", 64'(S_MXSE), 64'd1);
      instr = mk(1, 0, 5, 1, 15'h0005);
      tick();
      chk("imm_pos", 64'(outSE), 64'd5);

      // load-use bubble
      instr = mk_r(2, 0, 4, 1, 0);
      tick();
      chk("ld_memrd", 64'(MEM_RD), 64'd1);
      chk("ld_mxrb", 64'(S_MXRB), 64'd1);
      instr = mk_r(0, 2, 6, 4, 1);
      #1 chk("hz_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("hz_bubble", 64'(out_valid), 64'd0);
      chk("hz_ready_after", 64'(in_ready), 64'd1);
      tick();
      chk("hz_issue_valid", 64'(out_valid), 64'd1);
      chk("hz_issue_op", 64'(OP_ALU), 64'd2);

      // load to r0 never hazards
      instr = mk_r(2, 0, 0, 1, 0);
      tick();
      instr = mk_r(0, 2, 6, 0, 1);
      #1 chk("r0_no_hazard", 64'(in_ready), 64'd1);
      tick();
      chk("r0_issue", 64'(out_valid), 64'd1);

      // same-cycle write-back bypass
      instr = mk_r(0, 0, 7, 6, 1); wb_en = 1; wb_addr = 6; wb_data = 32'hA5A5_A5A5;
      tick();
      wb_en = 0;
      chk("bypass_PRA", 64'(PRA), 64'hA5A5_A5A5);

      // stall with flush on the second held cycle
      out_ready = 0; instr = mk_r(0, 1, 8, 1, 2);
      #1 chk("stall_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("stall_hold_PRA", 64'(PRA), 64'hA5A5_A5A5);
      chk("stall_hold_valid", 64'(out_valid), 64'd1);
      flush = 1;
      tick();
      flush = 0;
      chk("flush_valid", 64'(out_valid), 64'd0);
      tick();
      chk("after_flush_op", 64'(OP_ALU), 64'd1);
      out_ready = 1;

      // jump-and-link branch
      instr = mk_r(3, 5'b10101, 9, 1, 2);
      tick();
      chk("br_cond", 64'(cond), 64'd5);
      chk("br_mxpc", 64'(S_MXPC), 64'd1);
      chk("br_wrf", 64'(W_RF), 64'd1);
      chk("br_mxrb", 64'(S_MXRB), 64'd2);

      // reset mid-stream
      rst = 0;
      tick();
      chk("mrst_valid", 64'(out_valid), 64'd0);
      chk("mrst_cond", 64'(cond), 64'd0);
      chk("mrst_mxpc", 64'(S_MXPC), 64'd0);
      chk("mrst_PC", 64'(PC_o), 64'd0);
      rst = 1; instr = mk_r(0, 0, 3, 1, 2);
      tick();
      chk("mrst_reg_clear", 64'(PRA), 64'd0);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         logic [14:0] low;
         low       = 15'(($urandom_range(0, 7) << 10) | $urandom_range(0, 1023));
         instr     = mk($urandom_range(0, 3), $urandom_range(0, 31),
                        $urandom_range(0, 7), $urandom_range(0, 7), low);
         wpc       = $urandom();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         rst       = ($urandom_range(0, 199) != 0);
         wb_en     = ($urandom_range(0, 1) != 0);
         wb_addr   = 5'($urandom_range(0, 7));
         wb_data   = $urandom();
         tick();
      end

      rst = 1; in_valid = 0; flush = 0; wb_en = 0;
      tick(); tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
